maze_port_arbiter: RTL and testbench
====================================

// Module: maze_port_arbiter
// PURPOSE
//   Shares the single maze memory port (row/col select, oe, we, maze_in) between N_REQ
//   solver-side requesters, e.g. several maze walkers working on one labyrinth.
//   Round-robin arbitration, one access per cycle, pipelined reads, registered memory-side outputs.
//   Optional per-requester lock keeps the port across read-check-write sequences, guarded by a watchdog.
// PARAMETERS
//   N_REQ     2    number of requesters (2..8)
//   ADDR_W    6    row/col width (64x64 maze)
//   LOCK_MAX  15   max consecutive idle cycles a lock owner may hold the port
// PORTS
//   clk        in   1             clock, all logic on posedge
//   rst_n      in   1             asynchronous, active-low reset
//   req_valid  in   N_REQ         requester i has an access pending
//   req_we     in   N_REQ         1 = write (mark cell), 0 = read
//   req_lock   in   N_REQ         keep grant after this transfer
//   req_row    in   N_REQ*ADDR_W  row of requester i, bits [i*ADDR_W +: ADDR_W]
//   req_col    in   N_REQ*ADDR_W  col of requester i, same packing
//   req_ready  out  N_REQ         grant; transfer when req_valid[i] & req_ready[i]
//   rsp_valid  out  N_REQ         read data for requester i valid this cycle
//   rsp_data   out  1             read data (maze_in pass-through)
//   lock_err   out  1             one-cycle pulse: lock broken by watchdog
//   row        out  ADDR_W        maze row select (registered)
//   col        out  ADDR_W        maze col select (registered)
//   maze_oe    out  1             read enable (registered)
//   maze_we    out  1             write enable (registered)
//   maze_in    in   1             maze cell value, valid the cycle after maze_oe
// BEHAVIOUR
//   Reset (async, rst_n=0): row=0, col=0, maze_oe=0, maze_we=0, rsp_valid=0, lock_err=0,
//     state=IDLE, rr pointer=N_REQ-1 (requester 0 wins first), watchdog=0, in-flight reads dropped.
//   req_ready is combinational, at most one bit set, and only when that req_valid is set.
//   FSM IDLE: grant the first valid requester scanning from pointer+1 mod N_REQ.
//     On a transfer, pointer <= i. If req_lock[i]=1, go to LOCKED(owner=i).
//   FSM LOCKED: only the owner may be granted. Other requesters see ready=0.
//     An owner transfer with req_lock=0 returns the FSM to IDLE after that transfer.
//     Watchdog increments on each cycle with no owner transfer and clears on an owner transfer.
//     Watchdog reaching LOCK_MAX -> lock_err=1 for one cycle, state IDLE, pointer=owner.
//   Timing, transfer in cycle t:
//     cycle t+1: row/col = requester address; maze_oe = ~we, maze_we = we (never both high).
//     Read: rsp_valid[i]=1 in cycle t+2 with rsp_data=maze_in. Write: no response.
//   Back-to-back transfers are accepted every cycle, so up to 2 reads are in flight.
//   No transfer in cycle t -> maze_oe=maze_we=0 in t+1; row/col hold their last value.
//   Requester changing req_row/col/we while valid & ~ready is legal; the value sampled at the transfer is used.
//   Requester dropping req_valid mid-lock: legal; the watchdog eventually releases the port.
// TESTING
//   1. Reset, req_valid=01, req0 read (5,7) -> ready=01 @t; row=5,col=7,maze_oe=1 @t+1; rsp_valid=01 @t+2.
//   2. Both valid every cycle, no lock -> grants alternate 0,1,0,1; each gets 50% of port cycles.
//   3. req1 read+lock, then write (same cell) lock=0, req0 valid throughout -> req0 ready=0 until
//      the req1 write; maze_we=1 one cycle; req0 granted the next cycle.
//   4. req0 lock then idle 15 cycles, req1 valid -> lock_err pulse; req1 granted the following cycle.
//   5. rst_n low mid-read (after maze_oe) -> outputs 0 immediately; no rsp_valid after release;
//      first grant goes to req0.
//   6. Continuous reads of alternating cells with maze_in 1,0 -> rsp_data 1,0 in order, no bubbles.

Source files
------------

// File: rtl/maze_port_arbiter_if.sv
// Bundle of requester-side handshake, response and maze memory port signals
// shared between maze_port_arbiter (slave) and its environment (master).
interface maze_port_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 6
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_row;
  logic [N_REQ*ADDR_W-1:0] req_col;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic                    rsp_data;
  logic                    lock_err;
  logic [ADDR_W-1:0]       row;
  logic [ADDR_W-1:0]       col;
  logic                    maze_oe;
  logic                    maze_we;
  logic                    maze_in;

  modport master (
    output req_valid, req_we, req_lock, req_row, req_col, maze_in,
    input  req_ready, rsp_valid, rsp_data, lock_err, row, col, maze_oe, maze_we
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_row, req_col, maze_in,
    output req_ready, rsp_valid, rsp_data, lock_err, row, col, maze_oe, maze_we
  );
endinterface

// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing one maze memory port among N_REQ requesters,
// with optional per-requester lock released by an idle watchdog.
module maze_port_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  maze_port_arbiter_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned WD_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx;
  logic [ID_W-1:0]   owner, owner_nx;
  logic [WD_W-1:0]   wd, wd_nx;
  logic              lock_err_nx;

  logic [N_REQ-1:0]  grant_c;
  logic              xfer_c;
  logic [ID_W-1:0]   xfer_id_c;
  logic [ID_W-1:0]   scan_idx;
  logic [ADDR_W-1:0] sel_row, sel_col;
  logic              sel_we, sel_lock;

  // read pipeline stage between the memory strobe and the response
  logic              rd1_valid;
  logic [ID_W-1:0]   rd1_id;

  assign bus.req_ready = grant_c;
  assign bus.rsp_data  = bus.maze_in;

  // grant selection, payload mux and next-state logic
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    owner_nx    = owner;
    wd_nx       = wd;
    lock_err_nx = 1'b0;
    grant_c     = '0;
    xfer_c      = 1'b0;
    xfer_id_c   = '0;
    scan_idx    = '0;
    sel_row     = '0;
    sel_col     = '0;
    sel_we      = 1'b0;
    sel_lock    = 1'b0;

    if (state == IDLE) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        scan_idx = ID_W'((32'(ptr) + k) % N_REQ);
        if (!xfer_c && bus.req_valid[scan_idx]) begin
          grant_c[scan_idx] = 1'b1;
          xfer_c            = 1'b1;
          xfer_id_c         = scan_idx;
        end
      end
    end else if (bus.req_valid[owner]) begin
      grant_c[owner] = 1'b1;
      xfer_c         = 1'b1;
      xfer_id_c      = owner;
    end

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (xfer_id_c == ID_W'(i)) begin
        sel_row  = bus.req_row[i*ADDR_W +: ADDR_W];
        sel_col  = bus.req_col[i*ADDR_W +: ADDR_W];
        sel_we   = bus.req_we[i];
        sel_lock = bus.req_lock[i];
      end
    end

    if (xfer_c) ptr_nx = xfer_id_c;

    case (state)
      IDLE: begin
        if (xfer_c && sel_lock) begin
          state_nx = LOCKED;
          owner_nx = xfer_id_c;
          wd_nx    = '0;
        end
      end
      LOCKED: begin
        if (xfer_c) begin
          wd_nx = '0;
          if (!sel_lock) state_nx = IDLE;
        end else if ((32'(wd) + 32'd1) >= LOCK_MAX) begin
          wd_nx       = '0;
          lock_err_nx = 1'b1;
          state_nx    = IDLE;
          ptr_nx      = owner;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register and registered memory-side / response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= ID_W'(N_REQ - 1);
      owner         <= '0;
      wd            <= '0;
      rd1_valid     <= 1'b0;
      rd1_id        <= '0;
      bus.row       <= '0;
      bus.col       <= '0;
      bus.maze_oe   <= 1'b0;
      bus.maze_we   <= 1'b0;
      bus.rsp_valid <= '0;
      bus.lock_err  <= 1'b0;
    end else begin
      state         <= state_nx;
      ptr           <= ptr_nx;
      owner         <= owner_nx;
      wd            <= wd_nx;
      rd1_valid     <= xfer_c & ~sel_we;
      rd1_id        <= xfer_id_c;
      if (xfer_c) begin
        bus.row <= sel_row;
        bus.col <= sel_col;
      end
      bus.maze_oe   <= xfer_c & ~sel_we;
      bus.maze_we   <= xfer_c & sel_we;
      bus.rsp_valid <= rd1_valid ? (N_REQ'(1) << rd1_id) : '0;
      bus.lock_err  <= lock_err_nx;
    end
  end
endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed self-checking bench for maze_port_arbiter (N_REQ=2, ADDR_W=6, LOCK_MAX=15).
module tb_maze_port_arbiter;
  localparam int unsigned AW = 6;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  maze_port_arbiter_if #(.N_REQ(2), .ADDR_W(AW)) bus ();

  maze_port_arbiter #(.N_REQ(2), .ADDR_W(AW), .LOCK_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // next cycle, inputs change just after the active edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.maze_in   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.row, bus.col} !== 12'd0) begin
      failures++; $display("FAIL reset_rowcol got=%h want=0", {bus.row, bus.col});
    end
    checks++;
    if ({bus.maze_oe, bus.maze_we, bus.rsp_valid, bus.lock_err, bus.req_ready} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0",
               {bus.maze_oe, bus.maze_we, bus.rsp_valid, bus.lock_err, bus.req_ready});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_row   = {6'd0, 6'd5};
    bus.req_col   = {6'd0, 6'd7};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL single_ready got=%b want=01", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.row, bus.col, bus.maze_oe, bus.maze_we} !== {6'd5, 6'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_mem got row=%0d col=%0d oe=%b we=%b want 5 7 1 0",
               bus.row, bus.col, bus.maze_oe, bus.maze_we);
    end
    next_cycle();
    bus.maze_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== 3'b011) begin
      failures++;
      $display("FAIL single_rsp got v=%b d=%b want 01 1", bus.rsp_valid, bus.rsp_data);
    end
    next_cycle();
    bus.maze_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.maze_oe, bus.row} !== {2'b00, 1'b0, 6'd5}) begin
      failures++;
      $display("FAIL single_idle got v=%b oe=%b row=%0d want 00 0 5",
               bus.rsp_valid, bus.maze_oe, bus.row);
    end
  endtask

  task automatic test_round_robin();
    int          cnt0 = 0;
    int          cnt1 = 0;
    logic [1:0]  exp_g;
    logic [1:0]  prev_g = 2'b00;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_row   = {6'd2, 6'd1};
    bus.req_col   = {6'd4, 6'd3};
    for (int c = 0; c < 8; c++) begin
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp_g) begin
        failures++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, bus.req_ready, exp_g);
      end
      if (bus.req_ready == 2'b01) cnt0++;
      if (bus.req_ready == 2'b10) cnt1++;
      if (c > 0) begin
        checks++;
        if (bus.row !== ((prev_g == 2'b01) ? 6'd1 : 6'd2)) begin
          failures++; $display("FAIL rr_row c=%0d got=%0d", c, bus.row);
        end
      end
      prev_g = exp_g;
      next_cycle();
    end
    bus.req_valid = 2'b00;
    checks++;
    if (cnt0 != 4 || cnt1 != 4) begin
      failures++; $display("FAIL rr_share got %0d/%0d want 4/4", cnt0, cnt1);
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_lock  = 2'b10;
    bus.req_row   = {6'd3, 6'd9};
    bus.req_col   = {6'd4, 6'd9};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      failures++; $display("FAIL lock_first got=%b want=10", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.maze_oe, bus.row} !== {2'b00, 1'b1, 6'd3}) begin
      failures++;
      $display("FAIL lock_hold1 got rdy=%b oe=%b row=%0d want 00 1 3",
               bus.req_ready, bus.maze_oe, bus.row);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL lock_hold2 got rdy=%b rsp=%b want 00 10", bus.req_ready, bus.rsp_valid);
    end
    next_cycle();
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b10;
    bus.req_lock  = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      failures++; $display("FAIL lock_write_rdy got=%b want=10", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.maze_we, bus.maze_oe, bus.row, bus.col} !==
        {2'b01, 1'b1, 1'b0, 6'd3, 6'd4}) begin
      failures++;
      $display("FAIL lock_release got rdy=%b we=%b oe=%b row=%0d col=%0d want 01 1 0 3 4",
               bus.req_ready, bus.maze_we, bus.maze_oe, bus.row, bus.col);
    end
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.maze_we, bus.maze_oe, bus.row} !== {1'b0, 1'b1, 6'd9}) begin
      failures++;
      $display("FAIL lock_after got we=%b oe=%b row=%0d want 0 1 9",
               bus.maze_we, bus.maze_oe, bus.row);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_lock  = 2'b01;
    bus.req_row   = {6'd12, 6'd1};
    bus.req_col   = {6'd13, 6'd1};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL wd_lock got=%b want=01", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 2'b10;
    bus.req_lock  = 2'b00;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.lock_err} !== 3'b000) begin
        failures++;
        $display("FAIL wd_wait c=%0d got rdy=%b err=%b want 00 0", c, bus.req_ready, bus.lock_err);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.lock_err} !== 3'b101) begin
      failures++;
      $display("FAIL wd_fire got rdy=%b err=%b want 10 1", bus.req_ready, bus.lock_err);
    end
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.lock_err, bus.maze_oe, bus.row} !== {1'b0, 1'b1, 6'd12}) begin
      failures++;
      $display("FAIL wd_after got err=%b oe=%b row=%0d want 0 1 12",
               bus.lock_err, bus.maze_oe, bus.row);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_row   = {6'd0, 6'd21};
    bus.req_col   = {6'd0, 6'd22};
    next_cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.maze_oe !== 1'b1) begin
      failures++; $display("FAIL rstmid_oe got=%b want=1", bus.maze_oe);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.row, bus.col, bus.maze_oe, bus.maze_we} !== 14'd0) begin
      failures++;
      $display("FAIL rstmid_async got row=%0d col=%0d oe=%b want 0 0 0",
               bus.row, bus.col, bus.maze_oe);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00) begin
        failures++; $display("FAIL rstmid_rsp c=%0d got=%b want=00", c, bus.rsp_valid);
      end
      next_cycle();
    end
    bus.req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL rstmid_grant got=%b want=01", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    do_reset();
    bus.req_col = {6'd0, 6'd30};
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        bus.req_valid = 2'b01;
        bus.req_row   = {6'd0, (c % 2 == 0) ? 6'd10 : 6'd11};
      end else begin
        bus.req_valid = 2'b00;
      end
      exp_d       = (c >= 2) && ((c - 2) % 2 == 0);
      bus.maze_in = exp_d;
      @(negedge clk);
      if (c < 6) begin
        checks++;
        if (bus.req_ready !== 2'b01) begin
          failures++; $display("FAIL b2b_ready c=%0d got=%b want=01", c, bus.req_ready);
        end
      end
      if (c >= 1 && c <= 6) begin
        checks++;
        if ({bus.maze_oe, bus.maze_we, bus.row} !==
            {1'b1, 1'b0, ((c - 1) % 2 == 0) ? 6'd10 : 6'd11}) begin
          failures++;
          $display("FAIL b2b_mem c=%0d got oe=%b we=%b row=%0d",
                   c, bus.maze_oe, bus.maze_we, bus.row);
        end
      end
      if (c >= 2) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, exp_d}) begin
          failures++;
          $display("FAIL b2b_rsp c=%0d got v=%b d=%b want 01 %b",
                   c, bus.rsp_valid, bus.rsp_data, exp_d);
        end
      end
      next_cycle();
    end
    bus.maze_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_watchdog();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
